// File: rtl/lut_neuron_array.sv
// Array of run-time loadable LUT neurons behind a two-stage valid/ready pipeline.
// Tables are written in CONFIG, queried in RUN, and DRAIN flushes in-flight beats before reconfig.

module lut_neuron #(
   parameter int IN_BITS  = 6,
   parameter int OUT_BITS = 1
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                we_i,
   input  logic [IN_BITS-1:0]  waddr_i,
   input  logic [OUT_BITS-1:0] wdata_i,
   input  logic                s1_en_i,
   input  logic [IN_BITS-1:0]  in_i,
   input  logic                s2_en_i,
   output logic [OUT_BITS-1:0] out_o
);
   logic [OUT_BITS-1:0] tbl_q [2**IN_BITS];
   logic [IN_BITS-1:0]  addr_q;
   logic [OUT_BITS-1:0] out_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int a = 0; a < 2**IN_BITS; a++) tbl_q[a] <= '0;
         addr_q <= '0;
         out_q  <= '0;
      end else begin
         if (we_i)    tbl_q[waddr_i] <= wdata_i;
         if (s1_en_i) addr_q <= in_i;
         if (s2_en_i) out_q <= tbl_q[addr_q];
      end
   end

   assign out_o = out_q;
endmodule

module lut_neuron_array #(
   parameter int IN_BITS   = 6,
   parameter int OUT_BITS  = 1,
   parameter int N_NEURONS = 8,
   localparam int NW       = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          cfg_start,
   input  logic                          cfg_done,
   input  logic                          cfg_we,
   input  logic [NW-1:0]                 cfg_neuron,
   input  logic [IN_BITS-1:0]            cfg_addr,
   input  logic [OUT_BITS-1:0]           cfg_data,
   output logic                          cfg_err,
   output logic                          busy,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [N_NEURONS*IN_BITS-1:0]  in_data,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [N_NEURONS*OUT_BITS-1:0] out_data
);
   typedef enum logic [1:0] {ST_CONFIG, ST_RUN, ST_DRAIN} state_e;

   localparam logic [NW:0] N_LIM = (NW+1)'(N_NEURONS);

   state_e state_q, state_d;
   logic   s1_vld_q, s1_vld_d, s2_vld_q, s2_vld_d;
   logic   cfg_err_q, cfg_err_d;
   logic   s1_load, s2_load, in_fire, nbad, wr_ok;

   // cfg_done is only looked at in CONFIG and cfg_start only in RUN, which gives the
   // required priority when both pulse together.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_CONFIG: if (cfg_done) state_d = ST_RUN;
         ST_RUN:    if (cfg_start) state_d = ST_DRAIN;
         ST_DRAIN:  if (!s1_vld_q && !s2_vld_q) state_d = ST_CONFIG;
         default:   state_d = ST_CONFIG;
      endcase
   end

   assign s2_load  = !s2_vld_q || out_ready;
   assign s1_load  = !s1_vld_q || s2_load;
   assign in_ready = (state_q == ST_RUN) && s1_load;
   assign in_fire  = in_valid && in_ready;
   assign s2_vld_d = s2_load ? s1_vld_q : s2_vld_q;
   assign s1_vld_d = s1_load ? in_fire : s1_vld_q;

   assign nbad      = {1'b0, cfg_neuron} >= N_LIM;
   assign wr_ok     = cfg_we && (state_q == ST_CONFIG) && !nbad;
   assign cfg_err_d = cfg_err_q || (cfg_we && !wr_ok);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_CONFIG;
         s1_vld_q  <= 1'b0;
         s2_vld_q  <= 1'b0;
         cfg_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         s1_vld_q  <= s1_vld_d;
         s2_vld_q  <= s2_vld_d;
         cfg_err_q <= cfg_err_d;
      end
   end

   for (genvar n = 0; n < N_NEURONS; n++) begin : g_neuron
      lut_neuron #(.IN_BITS(IN_BITS), .OUT_BITS(OUT_BITS)) u_neuron (
         .clk     (clk),
         .rst_n   (rst_n),
         .we_i    (wr_ok && (cfg_neuron == NW'(n))),
         .waddr_i (cfg_addr),
         .wdata_i (cfg_data),
         .s1_en_i (in_fire),
         .in_i    (in_data[n*IN_BITS +: IN_BITS]),
         .s2_en_i (s2_load && s1_vld_q),
         .out_o   (out_data[n*OUT_BITS +: OUT_BITS])
      );
   end

   assign out_valid = s2_vld_q;
   assign busy      = (state_q != ST_CONFIG);
   assign cfg_err   = cfg_err_q;
endmodule
